// File: rtl/result_slot_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_slot_reader_pkg
// Description : Shared types and constants for the result-slot reader and the
//               matching address writer: FSM state encoding, default slot
//               geometry, read-timeout limit and the wrap-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package result_slot_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } rsr_state_t;

    localparam logic [31:0] DEFAULT_SLOT_STRIDE    = 32'h0000_060E;
    localparam int          DEFAULT_MAX_SLOTS      = 16;
    localparam int          DEFAULT_WORDS_PER_SLOT = 4;
    localparam logic [7:0]  TIMEOUT_LIMIT          = 8'd255;

    // Address one stride past the last slot; reaching it means "wrap to 0".
    function automatic logic [31:0] wrap_limit(input logic [31:0] stride,
                                               input int          slots);
        return stride * 32'(slots);
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_slot_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : result_slot_addr_gen
// Description : Holds the reader's current slot base address and steps it by
//               one stride on request, wrapping to 0 after MAX_SLOTS slots.
// Ports       : clk, rst (async, active-high)
//               i_advance - step to the next slot this cycle
//               o_rd_base - current slot base byte address
// Revision    : 1.0 - initial release
// ============================================================================
module result_slot_addr_gen
    import result_slot_reader_pkg::*;
#(
    parameter logic [31:0] SLOT_STRIDE = DEFAULT_SLOT_STRIDE,
    parameter int          MAX_SLOTS   = DEFAULT_MAX_SLOTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_advance,
    output logic [31:0] o_rd_base
);

    localparam logic [31:0] c_wrap_addr = wrap_limit(SLOT_STRIDE, MAX_SLOTS);

    logic [31:0] r_rd_base;
    logic [31:0] w_sum;
    logic [31:0] w_next;

    assign w_sum  = r_rd_base + SLOT_STRIDE;
    assign w_next = (w_sum == c_wrap_addr) ? 32'd0 : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_base <= 32'd0;
        end else if (i_advance) begin
            r_rd_base <= w_next;
        end
    end

    assign o_rd_base = r_rd_base;

endmodule
`default_nettype wire

// File: rtl/result_slot_reader.sv
`default_nettype none
// ============================================================================
// Module      : result_slot_reader
// Description : Reads completed result slots word by word from result memory
//               and hands each word to a consumer with a valid/ready handshake.
// Ports       : clk, rst (async, active-high)
//               wr_addr            - writer's current slot base
//               rd_req             - request the next complete slot
//               mem_addr/read_enable/mem_ack/mem_rdata - memory read port
//               data_out/data_valid/data_ready/last    - consumer port
//               empty, busy        - status
//               rd_error           - timeout pulse (RESULT_READ_TIMEOUT_EN only)
// Options     : RESULT_READ_TIMEOUT_EN - abandon a word after 255 WAIT cycles
//               without mem_ack, pulse rd_error and skip to the next slot.
// Revision    : 1.0 - initial release
// ============================================================================
module result_slot_reader
    import result_slot_reader_pkg::*;
#(
    parameter logic [31:0] SLOT_STRIDE    = DEFAULT_SLOT_STRIDE,
    parameter int          WORDS_PER_SLOT = DEFAULT_WORDS_PER_SLOT,
    parameter int          MAX_SLOTS      = DEFAULT_MAX_SLOTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_addr,
    input  logic        rd_req,
    output logic [31:0] mem_addr,
    output logic        read_enable,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        last,
    output logic        empty,
    output logic        busy
`ifdef RESULT_READ_TIMEOUT_EN
    ,
    output logic        rd_error
`endif
);

    rsr_state_t  r_state;
    rsr_state_t  w_state_next;
    logic [3:0]  r_word_idx;
    logic [31:0] r_data_out;
    logic [31:0] w_rd_base;
    logic        w_last_word;
    logic        w_capture;
    logic        w_advance;
    logic        w_idx_clr;
    logic        w_idx_inc;
`ifdef RESULT_READ_TIMEOUT_EN
    logic [7:0]  r_to_cnt;
    logic        w_timeout;
`endif

    result_slot_addr_gen #(
        .SLOT_STRIDE (SLOT_STRIDE),
        .MAX_SLOTS   (MAX_SLOTS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_advance),
        .o_rd_base (w_rd_base)
    );

    assign w_last_word = (r_word_idx == 4'(WORDS_PER_SLOT - 1));

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
`ifdef RESULT_READ_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // empty is only consulted here, so a moving wr_addr never
                // disturbs a slot already being read.
                if (rd_req && !empty) begin
                    w_state_next = ST_ISSUE;
                    w_idx_clr    = 1'b1;
                end
            end
            ST_ISSUE: begin
                // A same-cycle ack is legal and skips WAIT entirely.
                if (mem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
`ifdef RESULT_READ_TIMEOUT_EN
                else if (r_to_cnt == 8'(TIMEOUT_LIMIT - 8'd1)) begin
                    w_timeout    = 1'b1;
                    w_advance    = 1'b1;
                    w_state_next = ST_IDLE;
                end
`endif
            end
            ST_HOLD: begin
                if (data_ready) begin
                    if (w_last_word) begin
                        w_advance    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word_idx <= 4'd0;
            r_data_out <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_idx_clr) begin
                r_word_idx <= 4'd0;
            end else if (w_idx_inc) begin
                r_word_idx <= r_word_idx + 4'd1;
            end
            if (w_capture) begin
                r_data_out <= mem_rdata;
            end
        end
    end

`ifdef RESULT_READ_TIMEOUT_EN
    // Counts WAIT cycles of the current word; cleared whenever not waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == ST_WAIT) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end else begin
            r_to_cnt <= 8'd0;
        end
    end

    assign rd_error = w_timeout;
`endif

    assign read_enable = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign mem_addr    = read_enable ? (w_rd_base + {26'd0, r_word_idx, 2'b00}) : 32'd0;
    assign data_valid  = (r_state == ST_HOLD);
    assign data_out    = r_data_out;
    assign last        = data_valid && w_last_word;
    assign empty       = (w_rd_base == wr_addr);
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_result_slot_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_slot_reader
// Description : Self-checking bench for result_slot_reader: reset state, a
//               cycle-exact vector table for one slot, then directed
//               sequences for slow memory/consumer, slot wrap, mid-read reset
//               and (with RESULT_READ_TIMEOUT_EN) the read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_slot_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_addr;
    logic        rd_req;
    logic [31:0] mem_addr;
    logic        read_enable;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        last;
    logic        empty;
    logic        busy;
`ifdef RESULT_READ_TIMEOUT_EN
    logic        rd_error;
`endif

    int n_cmp = 0;
    int n_err = 0;

    result_slot_reader dut (
        .clk         (clk),
        .rst         (rst),
        .wr_addr     (wr_addr),
        .rd_req      (rd_req),
        .mem_addr    (mem_addr),
        .read_enable (read_enable),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .last        (last),
        .empty       (empty),
        .busy        (busy)
`ifdef RESULT_READ_TIMEOUT_EN
        ,
        .rd_error    (rd_error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_req;
        logic        ack;
        logic [31:0] rdata;
        logic        e_re;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dout;
        logic        e_last;
        logic        e_busy;
        logic        e_empty;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory contents as a function of address so every word is distinct.
    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rq, input logic ak, input logic [31:0] rd,
                                input logic re, input logic [31:0] ad, input logic dv,
                                input logic [31:0] dq, input logic ls, input logic bz,
                                input logic em);
        vec_t v;
        v = '{rq, ak, rd, re, ad, dv, dq, ls, bz, em};
        return v;
    endfunction

    // One word: read_enable for ack_dly+1 cycles (ack on the last), then
    // HOLD for rdy_dly+1 cycles (ready on the last).
    task automatic do_word(input int ack_dly, input int rdy_dly, input logic [31:0] ea,
                           input logic [31:0] rd, input logic el);
        for (int k = 0; k <= ack_dly; k++) begin
            @(negedge clk);
            rd_req     = 1'b0;
            data_ready = 1'b0;
            mem_ack    = (k == ack_dly);
            mem_rdata  = rd;
            #1;
            chk("word_read_enable", read_enable, 1);
            chk("word_mem_addr", mem_addr, ea);
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk);
            mem_ack    = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
            data_ready = (k == rdy_dly);
            #1;
            chk("hold_read_enable", read_enable, 0);
            chk("hold_data_valid", data_valid, 1);
            chk("hold_data_out", data_out, rd);
            chk("hold_last", last, el);
        end
    endtask

    task automatic read_slot(input logic [31:0] base, input int a0, input int r0);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("req_empty", empty, 0);
        chk("req_busy", busy, 0);
        for (int w = 0; w < 4; w++) begin
            do_word((w == 0) ? a0 : (w % 2), (w == 0) ? r0 : 0,
                    base + 32'(4 * w), dat(base + 32'(4 * w)), w == 3);
        end
        @(negedge clk);
        data_ready = 1'b0;
        #1;
        chk("slot_done_busy", busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        wr_addr    = 32'd0;
        rd_req     = 1'b1;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        data_ready = 1'b0;

        // Reset state, then requests against an empty buffer do nothing.
        @(negedge clk);
        #1;
        chk("rst_read_enable", read_enable, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("empty_req_re", read_enable, 0);
            chk("empty_req_busy", busy, 0);
            chk("empty_req_empty", empty, 1);
        end

        // One slot at base 0, ack in the first WAIT cycle, ready always high.
        tbl[0]  = mk(1, 0, 0,      0, 0,   0, 0,      0, 0, 0);
        tbl[1]  = mk(0, 0, 0,      1, 0,   0, 0,      0, 1, 0);
        tbl[2]  = mk(0, 1, dat(0), 1, 0,   0, 0,      0, 1, 0);
        tbl[3]  = mk(0, 0, 0,      0, 0,   1, dat(0), 0, 1, 0);
        tbl[4]  = mk(0, 0, 0,      1, 4,   0, 0,      0, 1, 0);
        tbl[5]  = mk(0, 1, dat(4), 1, 4,   0, 0,      0, 1, 0);
        tbl[6]  = mk(0, 0, 0,      0, 0,   1, dat(4), 0, 1, 0);
        tbl[7]  = mk(0, 0, 0,      1, 8,   0, 0,      0, 1, 0);
        tbl[8]  = mk(0, 1, dat(8), 1, 8,   0, 0,      0, 1, 0);
        tbl[9]  = mk(0, 0, 0,      0, 0,   1, dat(8), 0, 1, 0);
        tbl[10] = mk(0, 0, 0,      1, 12,  0, 0,      0, 1, 0);
        tbl[11] = mk(0, 1, dat(12),1, 12,  0, 0,      0, 1, 0);
        tbl[12] = mk(0, 0, 0,      0, 0,   1, dat(12),1, 1, 0);
        tbl[13] = mk(1, 0, 0,      0, 0,   0, 0,      0, 0, 1);
        tbl[14] = mk(0, 0, 0,      0, 0,   0, 0,      0, 0, 1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wr_addr    = 32'h0000_060E;
            data_ready = 1'b1;
            rd_req     = tbl[i].rd_req;
            mem_ack    = tbl[i].ack;
            mem_rdata  = tbl[i].rdata;
            #1;
            chk($sformatf("tbl%0d_re", i), read_enable, tbl[i].e_re);
            chk($sformatf("tbl%0d_dv", i), data_valid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_last", i), last, tbl[i].e_last);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
            if (tbl[i].e_re) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_dv) chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].e_dout);
        end
        rd_req     = 1'b0;
        data_ready = 1'b0;

        // Slow memory (ack 5 cycles after strobe) and slow consumer (3 cycles).
        wr_addr = 32'h0000_0C1C;
        read_slot(32'h0000_060E, 5, 3);

        // Walk forward to slot 15 (0x5AD2).
        wr_addr = 32'h0000_5AD2;
        for (int s = 2; s < 15; s++) read_slot(32'(s) * 32'h0000_060E, s % 2, 0);

        // Last slot, then base wraps to 0 and meets the writer at 0.
        wr_addr = 32'd0;
        read_slot(32'h0000_5AD2, 2, 1);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("wrap_empty", empty, 1);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("wrap_req_ignored", busy, 0);

        // Reset during WAIT of the second word.
        wr_addr = 32'h0000_060E;
        @(negedge clk);
        rd_req = 1'b1;
        do_word(1, 0, 32'd0, dat(32'd0), 1'b0);
        @(negedge clk);
        #1;
        chk("w2_issue_addr", mem_addr, 32'd4);
        @(negedge clk);
        #1;
        chk("w2_wait_re", read_enable, 1);
        rst = 1'b1;
        #1;
        chk("abort_re", read_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dout", data_out, 0);
        chk("abort_addr", mem_addr, 0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        chk("late_ack_busy", busy, 0);
        chk("late_ack_dv", data_valid, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_dout", data_out, 0);
        chk("abort_not_advanced", empty, 0);
        read_slot(32'd0, 0, 2);
        #1;
        chk("reread_empty", empty, 1);

`ifdef RESULT_READ_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            wr_addr = 32'h0000_0C1C;
            @(negedge clk);
            rd_req = 1'b1;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                rd_req = 1'b0;
                #1;
                cyc++;
                if (rd_error) break;
            end
            chk("timeout_cycle", cyc, 256);
            @(negedge clk);
            #1;
            chk("timeout_busy", busy, 0);
            chk("timeout_re", read_enable, 0);
            chk("timeout_pulse_end", rd_error, 0);
            chk("timeout_advanced", empty, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_slot_reader.md
RESULT_SLOT_READER -- requirements
Module: result_slot_reader

Interface
REQ-001 Parameter SLOT_STRIDE, default 32'h0000060E, byte distance between consecutive result slot base addresses.
REQ-002 Parameter WORDS_PER_SLOT, default 4, number of 32-bit words read per slot (range 1..16).
REQ-003 Parameter MAX_SLOTS, default 16, slot count before base address wraps to 0.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 wr_addr  input  32  writer's current slot base; slots below it (modulo wrap) are complete.
REQ-008 rd_req  input  1  single-cycle request to read the next complete slot.
REQ-009 mem_addr  output  32  byte address presented to result memory.
REQ-010 read_enable  output  1  memory read strobe, held until mem_ack.
REQ-011 mem_ack  input  1  memory has valid mem_rdata this cycle.
REQ-012 mem_rdata  input  32  memory read data.
REQ-013 data_out  output  32  word delivered to consumer.
REQ-014 data_valid  output  1  data_out valid; held until data_ready.
REQ-015 data_ready  input  1  consumer accepts data_out.
REQ-016 last  output  1  high with data_valid on final word of a slot.
REQ-017 empty  output  1  combinational: rd_base == wr_addr.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE -> ISSUE when rd_req && !empty; word index cleared to 0.
- rd_req while busy or empty is ignored, no side effects.
REQ-020 ISSUE: read_enable=1, mem_addr = rd_base + 4*word_idx; next state WAIT.
REQ-021 WAIT: read_enable and mem_addr held; on mem_ack capture mem_rdata into data_out, go HOLD; mem_ack in ISSUE same cycle also captures and goes HOLD.
REQ-022 HOLD: data_valid=1, data_out stable; on data_ready: if word_idx == WORDS_PER_SLOT-1 advance slot and go IDLE, else word_idx+1 and go ISSUE.
REQ-023 last = data_valid && (word_idx == WORDS_PER_SLOT-1).
REQ-024 Slot advance: rd_base + SLOT_STRIDE, 32-bit unsigned; result equal to MAX_SLOTS*SLOT_STRIDE (0x000060E0 default) wraps to 0.
REQ-025 Minimum latency rd_req to first data_valid: 3 cycles with mem_ack asserted in first WAIT cycle.
REQ-026 wr_addr changing mid-slot does not abort the current slot; empty re-evaluated only in IDLE.
REQ-027 mem_ack outside ISSUE/WAIT is ignored.

Reset
REQ-028 On rst: state IDLE, rd_base 0, word_idx 0, mem_addr 0, read_enable 0, data_out 0, data_valid 0, last 0, busy 0; empty then 1 iff wr_addr == 0.
REQ-029 rst mid-read aborts immediately; slot not advanced, in-flight mem_ack discarded.

Configuration
REQ-030 Macro RESULT_READ_TIMEOUT_EN: when defined, 8-bit counter in WAIT; 255 cycles without mem_ack -> read_enable drops, output rd_error pulses 1 cycle, slot advanced, state IDLE.
REQ-031 Without RESULT_READ_TIMEOUT_EN: no rd_error port, WAIT waits indefinitely.

Structure
REQ-032 Shared package holds state enum type, default SLOT_STRIDE, MAX_SLOTS and timeout limit constants, reused by the address writer block.
REQ-033 One sub-module: result_slot_addr_gen (rd_base register, stride add, wrap compare).

Verification
REQ-034 Reset, wr_addr=0, rd_req=1 -> empty=1, busy=0, read_enable never asserts.
REQ-035 wr_addr=0x060E, rd_req, mem_ack 1 cycle after strobe, data_ready=1 -> mem_addr 0x0,0x4,0x8,0xC; 4 words out, last on 4th; then rd_base=0x060E, empty=1.
REQ-036 mem_ack delayed 5 cycles, data_ready low 3 cycles in HOLD -> read_enable held 6 cycles, data_out/data_valid stable until ready.
REQ-037 rd_base=0x5AD2 (slot 15), wr_addr=0 after wrap -> slot read at 0x5AD2..0x5ADE, rd_base wraps to 0x0, empty=1.
REQ-038 rst asserted during WAIT of word 2 -> all outputs 0 next edge, rd_base unchanged, late mem_ack ignored.
REQ-039 RESULT_READ_TIMEOUT_EN defined, mem_ack never asserted -> rd_error pulse at WAIT cycle 255, rd_base +0x060E, busy=0.
